packed_vector_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the shared 10-bit packed status vector driven toward the VGA/sound side of the game. Up to four game-logic requesters each present a 4-bit code and a 6-bit value. The block grants one requester at a time, packs its fields into a registered 10-bit vector, and holds that vector valid for a programmable number of cycles. It then acknowledges the requester and rotates priority.

---
 rtl/packed_vector_arbiter_if.sv | 23 ++
 rtl/packed_vector_arbiter.sv | 135 +++++++++++++
 tb/tb_packed_vector_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/packed_vector_arbiter_if.sv
// rtl/packed_vector_arbiter_if.sv - requester/packed-vector bundle between game logic and the arbiter
interface packed_vector_arbiter_if;
    logic [3:0]  req;
    logic [15:0] input1_flat;
    logic [23:0] input2_flat;
    logic [9:0]  outputVec;
    logic        outValid;
    logic [3:0]  grant;
    logic [3:0]  ack;
    logic        busy;

    // Game-logic side: raises requests and presents code/value fields.
    modport master (
        output req, input1_flat, input2_flat,
        input  outputVec, outValid, grant, ack, busy
    );

    // Arbiter side: owns the packed vector and the grant/ack handshake.
    modport slave (
        input  req, input1_flat, input2_flat,
        output outputVec, outValid, grant, ack, busy
    );
endinterface

// File: rtl/packed_vector_arbiter.sv
// rtl/packed_vector_arbiter.sv - round-robin arbiter that packs and holds one requester's code/value
module packed_vector_arbiter #(
    parameter int HOLD_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    resetN,
    packed_vector_arbiter_if.slave  bus
);

    typedef enum logic {
        ST_IDLE,
        ST_HOLD
    } state_t;

    // Counter is loaded with HOLD_CYCLES-1 so ack lands on the last valid cycle.
    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    state_t      r_state,      w_state_nxt;
    logic [7:0]  r_cnt,        w_cnt_nxt;
    logic [1:0]  r_last_grant, w_last_grant_nxt;
    logic [1:0]  r_gidx,       w_gidx_nxt;
    logic [9:0]  r_vec,        w_vec_nxt;
    logic        r_valid,      w_valid_nxt;
    logic [3:0]  r_grant,      w_grant_nxt;
    logic [3:0]  r_ack,        w_ack_nxt;
    logic        r_busy,       w_busy_nxt;

    logic        w_found;
    logic [1:0]  w_sel;
    logic [1:0]  w_idx;
    logic [3:0]  w_code;
    logic [5:0]  w_val;
    logic [3:0]  w_sel_onehot;

    // Round-robin scan starting just after the last owner; the last owner itself comes last.
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_last_grant;
        w_idx   = r_last_grant;
        for (int i = 1; i <= 4; i++) begin
            w_idx = r_last_grant + 2'(i);
            if (!w_found && bus.req[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    assign w_code       = bus.input1_flat[w_sel*4 +: 4];
    assign w_val        = bus.input2_flat[w_sel*6 +: 6];
    assign w_sel_onehot = 4'b0001 << w_sel;

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_last_grant_nxt = r_last_grant;
        w_gidx_nxt       = r_gidx;
        w_vec_nxt        = r_vec;
        w_valid_nxt      = r_valid;
        w_grant_nxt      = r_grant;
        w_ack_nxt        = 4'b0000;
        w_busy_nxt       = r_busy;
        case (r_state)
            ST_IDLE: begin
                w_valid_nxt = 1'b0;
                w_grant_nxt = 4'b0000;
                w_busy_nxt  = 1'b0;
                if (w_found) begin
                    w_state_nxt = ST_HOLD;
                    w_vec_nxt   = {w_val, w_code};
                    w_gidx_nxt  = w_sel;
                    w_grant_nxt = w_sel_onehot;
                    w_valid_nxt = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_cnt_nxt   = HOLD_LOAD;
                    // A one-cycle hold acks on its only HOLD cycle.
                    if (HOLD_LOAD == 8'd0) begin
                        w_ack_nxt = w_sel_onehot;
                    end
                end
            end
            ST_HOLD: begin
                if (r_cnt == 8'd0) begin
                    w_state_nxt      = ST_IDLE;
                    w_last_grant_nxt = r_gidx;
                    w_valid_nxt      = 1'b0;
                    w_grant_nxt      = 4'b0000;
                    w_busy_nxt       = 1'b0;
                    w_cnt_nxt        = 8'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                    if (r_cnt == 8'd1) begin
                        w_ack_nxt = r_grant;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transfer in flight.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 8'd0;
            r_last_grant <= 2'd3;
            r_gidx       <= 2'd0;
            r_vec        <= 10'd0;
            r_valid      <= 1'b0;
            r_grant      <= 4'b0000;
            r_ack        <= 4'b0000;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_gidx       <= w_gidx_nxt;
            r_vec        <= w_vec_nxt;
            r_valid      <= w_valid_nxt;
            r_grant      <= w_grant_nxt;
            r_ack        <= w_ack_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

    assign bus.outputVec = r_vec;
    assign bus.outValid  = r_valid;
    assign bus.grant     = r_grant;
    assign bus.ack       = r_ack;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_packed_vector_arbiter.sv
// tb/tb_packed_vector_arbiter.sv - directed self-checking bench for packed_vector_arbiter
module tb_packed_vector_arbiter;

    logic        clk;
    logic        resetN;
    logic [3:0]  req;
    logic [15:0] input1_flat;
    logic [23:0] input2_flat;
    logic        sel;

    int n_chk;
    int n_err;

    packed_vector_arbiter_if bus8 ();
    packed_vector_arbiter_if bus1 ();

    assign bus8.req         = req;
    assign bus8.input1_flat = input1_flat;
    assign bus8.input2_flat = input2_flat;
    assign bus1.req         = req;
    assign bus1.input1_flat = input1_flat;
    assign bus1.input2_flat = input2_flat;

    packed_vector_arbiter #(.HOLD_CYCLES(8)) dut8 (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus8)
    );

    packed_vector_arbiter #(.HOLD_CYCLES(1)) dut1 (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus1)
    );

    logic [9:0] m_vec;
    logic       m_valid;
    logic [3:0] m_grant;
    logic [3:0] m_ack;
    logic       m_busy;

    assign m_vec   = sel ? bus1.outputVec : bus8.outputVec;
    assign m_valid = sel ? bus1.outValid  : bus8.outValid;
    assign m_grant = sel ? bus1.grant     : bus8.grant;
    assign m_ack   = sel ? bus1.ack       : bus8.ack;
    assign m_busy  = sel ? bus1.busy      : bus8.busy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_table();
        input1_flat = 16'h8765;
        input2_flat = {6'h13, 6'h12, 6'h11, 6'h10};
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        req         = 4'($urandom);
        input1_flat = 16'($urandom);
        input2_flat = 24'($urandom);
        resetN      = 1'b0;
        #1;
        chk("rst_vec",   m_vec,   0);
        chk("rst_valid", m_valid, 0);
        chk("rst_grant", m_grant, 0);
        chk("rst_ack",   m_ack,   0);
        chk("rst_busy",  m_busy,  0);
        @(posedge clk);
        #1;
        req = 4'b0000;
        load_table();
        resetN = 1'b1;
    endtask

    task automatic xfer(input logic [3:0] g, input logic [9:0] vec, input int hold, input bit perturb);
        @(posedge clk);
        #1;
        for (int j = 0; j < hold; j++) begin
            chk("valid", m_valid, 1);
            chk("grant", m_grant, g);
            chk("vec",   m_vec,   vec);
            chk("busy",  m_busy,  1);
            chk("ack",   m_ack,   (j == hold - 1) ? g : 4'b0000);
            if (perturb && j == 2) begin
                input1_flat = ~input1_flat;
                input2_flat = ~input2_flat;
                req         = 4'b0000;
            end
            if (j == hold - 1) req = req & ~g;
            @(posedge clk);
            #1;
        end
        chk("idle_valid", m_valid, 0);
        chk("idle_grant", m_grant, 0);
        chk("idle_ack",   m_ack,   0);
        chk("idle_busy",  m_busy,  0);
        chk("idle_vec",   m_vec,   vec);
    endtask

    logic [3:0] rr_g   [5];
    logic [9:0] rr_vec [5];

    initial begin
        n_chk       = 0;
        n_err       = 0;
        sel         = 1'b0;
        resetN      = 1'b0;
        req         = 4'b0000;
        input1_flat = 16'h0;
        input2_flat = 24'h0;
        rr_g   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr_vec = '{10'h105, 10'h116, 10'h127, 10'h138, 10'h105};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("quiet_valid", m_valid, 0);
        end

        input1_flat = 16'h0A00;
        input2_flat = 24'h02B000;
        req         = 4'b0100;
        xfer(4'b0100, 10'h2BA, 8, 1'b0);

        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            xfer(rr_g[i], rr_vec[i], 8, 1'b0);
            req = 4'b1111;
        end

        req = 4'b0100;
        xfer(4'b0100, 10'h127, 8, 1'b0);
        req = 4'b0101;
        xfer(4'b0001, 10'h105, 8, 1'b0);
        xfer(4'b0100, 10'h127, 8, 1'b0);

        req = 4'b0010;
        xfer(4'b0010, 10'h116, 8, 1'b1);
        @(posedge clk);
        #1;
        chk("frz_idle_valid", m_valid, 0);
        chk("frz_idle_grant", m_grant, 0);
        load_table();

        req = 4'b1111;
        @(posedge clk);
        #1;
        chk("mid_grant", m_grant, 4'b0100);
        @(posedge clk);
        #3;
        resetN = 1'b0;
        #1;
        chk("mid_rst_vec",   m_vec,   0);
        chk("mid_rst_valid", m_valid, 0);
        chk("mid_rst_grant", m_grant, 0);
        chk("mid_rst_busy",  m_busy,  0);
        @(posedge clk);
        #1;
        resetN = 1'b1;
        xfer(4'b0001, 10'h105, 8, 1'b0);

        sel = 1'b1;
        do_reset();
        req = 4'b0010;
        xfer(4'b0010, 10'h116, 1, 1'b0);
        req = 4'b1111;
        xfer(4'b0100, 10'h127, 1, 1'b0);
        req = 4'b1111;
        xfer(4'b1000, 10'h138, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
